// File: rtl/safe_domain_ack_ctrl_if.sv
// ----------------------------------------------------------------------------
// safe_domain_ack_ctrl_if
//   Bundles the per-channel request/ack, lock-control, power and timeout
//   signals of safe_domain_ack_ctrl. Signal names carry the direction as seen
//   from the ack controller (_i = into the controller, _o = out of it).
//
//   Handshake: req_i[c] is a free-running asynchronous level. The controller
//   answers a 0->1 request edge by raising ack_o[c] and a 1->0 request edge by
//   dropping it, unless the channel is locked, a lock is being set that cycle,
//   or the power domain is down. Events that arrive while blocked are dropped.
//   There is no back-pressure: the requester simply watches ack_o.
//
// Modports
//   slave  : the ack controller (consumes requests and controls, drives acks)
//   master : the bus bridge / testbench side
//
// Signals
//   req_i            N_CH      async request levels
//   lock_set_i       N_CH      sync pulse, set lock of a channel
//   unlock_i         1         sync pulse, keyed unlock request
//   unlock_key_i     16        key sampled with unlock_i
//   unlock_mask_i    N_CH      channels released when the key matches
//   pwr_down_i       1         safe power domain down / transitioning
//   timeout_cycles_i TO_WIDTH  ack-high cycle limit, 0 disables
//   ack_o            N_CH      registered ack levels
//   lock_o           N_CH      registered lock bits
//   timeout_o        N_CH      sticky timeout flags
//   key_err_o        1         one-cycle pulse on a wrong unlock key
//   state_dbg_o      N_CH      per-channel FSM state (1 = ACK)
// ----------------------------------------------------------------------------
interface safe_domain_ack_ctrl_if #(
    parameter int N_CH     = 4,
    parameter int TO_WIDTH = 8
);
    logic [N_CH-1:0]     req_i;
    logic [N_CH-1:0]     lock_set_i;
    logic                unlock_i;
    logic [15:0]         unlock_key_i;
    logic [N_CH-1:0]     unlock_mask_i;
    logic                pwr_down_i;
    logic [TO_WIDTH-1:0] timeout_cycles_i;
    logic [N_CH-1:0]     ack_o;
    logic [N_CH-1:0]     lock_o;
    logic [N_CH-1:0]     timeout_o;
    logic                key_err_o;
    logic [N_CH-1:0]     state_dbg_o;

    modport slave (
        input  req_i, lock_set_i, unlock_i, unlock_key_i, unlock_mask_i,
               pwr_down_i, timeout_cycles_i,
        output ack_o, lock_o, timeout_o, key_err_o, state_dbg_o
    );

    modport master (
        output req_i, lock_set_i, unlock_i, unlock_key_i, unlock_mask_i,
               pwr_down_i, timeout_cycles_i,
        input  ack_o, lock_o, timeout_o, key_err_o, state_dbg_o
    );
endinterface

// File: rtl/safe_domain_ack_ctrl.sv
// ----------------------------------------------------------------------------
// safe_domain_ack_ctrl
//   Multi-channel level-ack generator between the safe-domain bus bridge and
//   the register bank. Each channel synchronises its async request, detects
//   edges, and runs a two-state FSM (IDLE/ACK). A per-channel lock freezes the
//   ack in either direction; locks survive power-domain transitions and clear
//   only on rstn_i or a keyed unlock. Acks held too long raise a sticky
//   timeout flag.
//
// Ports
//   clk_i   in  clock
//   rstn_i  in  asynchronous active-low reset
//   bus_if  slave modport of safe_domain_ack_ctrl_if (requests, lock
//           control, power, timeout limit in; ack/lock/timeout/key_err and
//           FSM state out)
// ----------------------------------------------------------------------------
module safe_domain_ack_ctrl #(
    parameter int          N_CH        = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          TO_WIDTH    = 8,
    parameter int unsigned LOCK_ON_ACK = 1,
    parameter logic [15:0] UNLOCK_KEY  = 16'hA5C3
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    safe_domain_ack_ctrl_if.slave  bus_if
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e                 r_state     [N_CH];
    state_e                 w_state_nxt [N_CH];
    logic [SYNC_STAGES-1:0] r_sync      [N_CH];
    logic [TO_WIDTH-1:0]    r_cnt       [N_CH];
    logic [TO_WIDTH-1:0]    w_cnt_nxt   [N_CH];

    logic [N_CH-1:0] r_req_d;
    logic [N_CH-1:0] r_lock;
    logic [N_CH-1:0] r_timeout;
    logic            r_key_err;

    logic [N_CH-1:0] w_req_s;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_blk;
    logic [N_CH-1:0] w_go_ack;
    logic [N_CH-1:0] w_lock_nxt;
    logic [N_CH-1:0] w_timeout_nxt;
    logic            w_key_ok;
    logic            w_unlock_ok;
    logic            w_to_en;

    // ------------------------------------------------------------------
    // Next-state, lock, and timeout logic
    // ------------------------------------------------------------------
    always_comb begin
        w_key_ok    = (bus_if.unlock_key_i == UNLOCK_KEY);
        w_unlock_ok = bus_if.unlock_i & w_key_ok;
        w_to_en     = (bus_if.timeout_cycles_i != '0);

        for (int c = 0; c < N_CH; c++) begin
            w_req_s[c]       = r_sync[c][SYNC_STAGES-1];
            w_rise[c]        = w_req_s[c] & ~r_req_d[c];
            w_fall[c]        = ~w_req_s[c] & r_req_d[c];
            w_blk[c]         = r_lock[c] | bus_if.lock_set_i[c] | bus_if.pwr_down_i;
            w_state_nxt[c]   = r_state[c];
            w_go_ack[c]      = 1'b0;
            w_lock_nxt[c]    = r_lock[c];
            w_cnt_nxt[c]     = '0;
            w_timeout_nxt[c] = r_timeout[c];

            if (bus_if.pwr_down_i) begin
                // Unlocked channels collapse to IDLE; locked ones keep their ack.
                if (!r_lock[c]) begin
                    w_state_nxt[c] = ST_IDLE;
                end
            end else begin
                case (r_state[c])
                    ST_IDLE: begin
                        if (w_rise[c] && !w_blk[c]) begin
                            w_state_nxt[c] = ST_ACK;
                            w_go_ack[c]    = 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (w_fall[c] && !w_blk[c]) begin
                            w_state_nxt[c] = ST_IDLE;
                        end
                    end
                    default: w_state_nxt[c] = ST_IDLE;
                endcase
            end

            // Setting a lock takes priority over a same-cycle unlock.
            if (bus_if.lock_set_i[c] || ((LOCK_ON_ACK != 0) && w_go_ack[c])) begin
                w_lock_nxt[c] = 1'b1;
            end else if (w_unlock_ok && bus_if.unlock_mask_i[c]) begin
                w_lock_nxt[c] = 1'b0;
            end

            // Counter runs only while acked, unlocked, powered and enabled;
            // every other situation (IDLE, locked, entering ACK) clears it.
            if (!bus_if.pwr_down_i && (r_state[c] == ST_ACK) && !r_lock[c] && w_to_en) begin
                if (r_cnt[c] != {TO_WIDTH{1'b1}}) begin
                    w_cnt_nxt[c] = r_cnt[c] + TO_WIDTH'(1);
                end else begin
                    w_cnt_nxt[c] = r_cnt[c];
                end
                if (r_cnt[c] == bus_if.timeout_cycles_i) begin
                    w_timeout_nxt[c] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= ST_IDLE;
                r_sync[c]  <= '0;
                r_cnt[c]   <= '0;
            end
            r_req_d   <= '0;
            r_lock    <= '0;
            r_timeout <= '0;
            r_key_err <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_sync[c]  <= {r_sync[c][SYNC_STAGES-2:0], bus_if.req_i[c]};
                r_cnt[c]   <= w_cnt_nxt[c];
            end
            // req_d always tracks req_s, so edges seen while blocked or
            // powered down are consumed rather than replayed later.
            r_req_d   <= w_req_s;
            r_lock    <= w_lock_nxt;
            r_timeout <= w_timeout_nxt;
            r_key_err <= bus_if.unlock_i & ~w_key_ok;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus_if.ack_o       = '0;
        bus_if.state_dbg_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            bus_if.ack_o[c]       = (r_state[c] != ST_IDLE);
            bus_if.state_dbg_o[c] = r_state[c];
        end
        bus_if.lock_o    = r_lock;
        bus_if.timeout_o = r_timeout;
        bus_if.key_err_o = r_key_err;
    end

endmodule

// File: tb/tb_safe_domain_ack_ctrl.sv
// ----------------------------------------------------------------------------
// tb_safe_domain_ack_ctrl
//   Directed bench for safe_domain_ack_ctrl. Two instances share clock and
//   reset: u_dut0 with LOCK_ON_ACK=0 and u_dut1 with LOCK_ON_ACK=1.
//   Inputs change 1 ns after a rising edge; outputs are checked at that same
//   point, i.e. they reflect the registers updated by the preceding edge.
// ----------------------------------------------------------------------------
module tb_safe_domain_ack_ctrl;

    localparam int N_CH     = 4;
    localparam int TO_WIDTH = 8;

    logic clk_i;
    logic rstn_i;

    int n_checks;
    int n_fail;

    safe_domain_ack_ctrl_if #(.N_CH(N_CH), .TO_WIDTH(TO_WIDTH)) if0 ();
    safe_domain_ack_ctrl_if #(.N_CH(N_CH), .TO_WIDTH(TO_WIDTH)) if1 ();

    safe_domain_ack_ctrl #(
        .N_CH(N_CH), .SYNC_STAGES(2), .TO_WIDTH(TO_WIDTH),
        .LOCK_ON_ACK(0), .UNLOCK_KEY(16'hA5C3)
    ) u_dut0 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus_if (if0)
    );

    safe_domain_ack_ctrl #(
        .N_CH(N_CH), .SYNC_STAGES(2), .TO_WIDTH(TO_WIDTH),
        .LOCK_ON_ACK(1), .UNLOCK_KEY(16'hA5C3)
    ) u_dut1 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus_if (if1)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        if0.req_i = '0; if0.lock_set_i = '0; if0.unlock_i = 1'b0;
        if0.unlock_key_i = '0; if0.unlock_mask_i = '0; if0.pwr_down_i = 1'b0;
        if0.timeout_cycles_i = '0;
        if1.req_i = '0; if1.lock_set_i = '0; if1.unlock_i = 1'b0;
        if1.unlock_key_i = '0; if1.unlock_mask_i = '0; if1.pwr_down_i = 1'b0;
        if1.timeout_cycles_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_i = 1'b0;
        tick(2);
        rstn_i = 1'b1;
        tick(1);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn_i   = 1'b0;
        clear_inputs();
        tick(1);
        do_reset();

        // 1: async reset mid-ACK with a lock held
        check_eq("reset_ack", 32'(if0.ack_o), 32'h0);
        if0.req_i[0] = 1'b1;
        tick(3);
        check_eq("t1_ack_up", 32'(if0.ack_o), 32'h1);
        if0.lock_set_i[0] = 1'b1;
        tick(1);
        if0.lock_set_i[0] = 1'b0;
        check_eq("t1_locked", 32'(if0.lock_o), 32'h1);
        #2;
        rstn_i = 1'b0;
        #1;
        check_eq("t1_async_ack", 32'(if0.ack_o), 32'h0);
        check_eq("t1_async_lock", 32'(if0.lock_o), 32'h0);
        check_eq("t1_async_to", 32'(if0.timeout_o), 32'h0);
        check_eq("t1_async_kerr", 32'(if0.key_err_o), 32'h0);
        clear_inputs();
        tick(2);
        rstn_i = 1'b1;
        tick(1);
        check_eq("t1_post_ack", 32'(if0.ack_o), 32'h0);
        check_eq("t1_post_lock", 32'(if0.lock_o), 32'h0);

        // 2: latency with LOCK_ON_ACK=0
        do_reset();
        if0.req_i[0] = 1'b1;
        tick(2);
        check_eq("t2_ack_edge1", 32'(if0.ack_o), 32'h0);
        tick(1);
        check_eq("t2_ack_edge2", 32'(if0.ack_o), 32'h1);
        check_eq("t2_no_lock", 32'(if0.lock_o), 32'h0);
        if0.req_i[0] = 1'b0;
        tick(2);
        check_eq("t2_fall_edge1", 32'(if0.ack_o), 32'h1);
        tick(1);
        check_eq("t2_fall_edge2", 32'(if0.ack_o), 32'h0);

        // 3: LOCK_ON_ACK=1, keyed unlock
        do_reset();
        if1.req_i[1] = 1'b1;
        tick(3);
        check_eq("t3_ack", 32'(if1.ack_o), 32'h2);
        check_eq("t3_lock", 32'(if1.lock_o), 32'h2);
        if1.req_i[1] = 1'b0;
        tick(4);
        check_eq("t3_frozen_ack", 32'(if1.ack_o), 32'h2);
        if1.unlock_i = 1'b1; if1.unlock_key_i = 16'h1234; if1.unlock_mask_i = 4'b0010;
        tick(1);
        if1.unlock_i = 1'b0;
        check_eq("t3_kerr_pulse", 32'(if1.key_err_o), 32'h1);
        check_eq("t3_lock_kept", 32'(if1.lock_o), 32'h2);
        tick(1);
        check_eq("t3_kerr_clear", 32'(if1.key_err_o), 32'h0);
        if1.unlock_i = 1'b1; if1.unlock_key_i = 16'hA5C3;
        tick(1);
        if1.unlock_i = 1'b0;
        check_eq("t3_unlocked", 32'(if1.lock_o), 32'h0);
        check_eq("t3_good_no_kerr", 32'(if1.key_err_o), 32'h0);
        check_eq("t3_ack_after_unl", 32'(if1.ack_o), 32'h2);
        if1.req_i[1] = 1'b1;
        tick(4);
        check_eq("t3_rise_in_ack", 32'(if1.ack_o), 32'h2);
        check_eq("t3_rise_in_ack_lk", 32'(if1.lock_o), 32'h0);
        if1.req_i[1] = 1'b0;
        tick(2);
        check_eq("t3_fall_pending", 32'(if1.ack_o), 32'h2);
        tick(1);
        check_eq("t3_fall_done", 32'(if1.ack_o), 32'h0);
        if1.req_i[1] = 1'b1;
        tick(3);
        check_eq("t3_reack", 32'(if1.ack_o), 32'h2);
        check_eq("t3_relock", 32'(if1.lock_o), 32'h2);

        // 4: power-down with one locked and one unlocked channel
        do_reset();
        if0.req_i[0] = 1'b1; if0.req_i[2] = 1'b1;
        tick(3);
        check_eq("t4_both_ack", 32'(if0.ack_o), 32'h5);
        if0.lock_set_i[0] = 1'b1;
        tick(1);
        if0.lock_set_i[0] = 1'b0;
        check_eq("t4_lock0", 32'(if0.lock_o), 32'h1);
        if0.pwr_down_i = 1'b1;
        tick(10);
        check_eq("t4_pd_ack", 32'(if0.ack_o), 32'h1);
        check_eq("t4_pd_lock", 32'(if0.lock_o), 32'h1);
        if0.pwr_down_i = 1'b0;
        tick(5);
        check_eq("t4_exit_no_ack", 32'(if0.ack_o), 32'h1);
        if0.req_i[2] = 1'b0;
        tick(3);
        if0.req_i[2] = 1'b1;
        tick(2);
        check_eq("t4_rise_pending", 32'(if0.ack_o), 32'h1);
        tick(1);
        check_eq("t4_fresh_rise", 32'(if0.ack_o), 32'h5);

        // 5: lock_set coinciding with fall, then with rise
        do_reset();
        if0.req_i[3] = 1'b1;
        tick(3);
        check_eq("t5_ack3", 32'(if0.ack_o), 32'h8);
        if0.req_i[3] = 1'b0;
        tick(2);
        if0.lock_set_i[3] = 1'b1;
        tick(1);
        if0.lock_set_i[3] = 1'b0;
        check_eq("t5_fall_lock_ack", 32'(if0.ack_o), 32'h8);
        check_eq("t5_fall_lock_lk", 32'(if0.lock_o), 32'h8);
        tick(3);
        check_eq("t5_fall_hold", 32'(if0.ack_o), 32'h8);
        do_reset();
        if0.req_i[3] = 1'b1;
        tick(2);
        if0.lock_set_i[3] = 1'b1;
        tick(1);
        if0.lock_set_i[3] = 1'b0;
        check_eq("t5_rise_lock_ack", 32'(if0.ack_o), 32'h0);
        check_eq("t5_rise_lock_lk", 32'(if0.lock_o), 32'h8);
        tick(3);
        check_eq("t5_rise_hold", 32'(if0.ack_o), 32'h0);

        // 6: timeout
        do_reset();
        if0.timeout_cycles_i = 8'd5;
        if0.req_i[0] = 1'b1;
        tick(3);
        check_eq("t6_ack", 32'(if0.ack_o), 32'h1);
        tick(5);
        check_eq("t6_to_edge5", 32'(if0.timeout_o), 32'h0);
        tick(1);
        check_eq("t6_to_edge6", 32'(if0.timeout_o), 32'h1);
        if0.req_i[0] = 1'b0;
        tick(4);
        check_eq("t6_ack_dropped", 32'(if0.ack_o), 32'h0);
        check_eq("t6_to_sticky", 32'(if0.timeout_o), 32'h1);
        do_reset();
        check_eq("t6_to_reset", 32'(if0.timeout_o), 32'h0);
        if0.timeout_cycles_i = 8'd0;
        if0.req_i[1] = 1'b1;
        tick(300);
        check_eq("t6_disabled_ack", 32'(if0.ack_o), 32'h2);
        check_eq("t6_disabled_to", 32'(if0.timeout_o), 32'h0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
